// File: rtl/axi_rd_burst_seq.sv
// Purpose: AXI read-slave burst sequencer; one AR burst at a time, FIXED/INCR/WRAP
//   address walk over a 1-cycle-latency synchronous memory, R beats with RLAST.
// Latency: AR handshake at T -> mem_re at T+1 -> rvalid at T+2; 2 cycles per beat minimum.
// Backpressure: R beat held stable while rready=0; arready low for the whole burst.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   arid/araddr/arlen/arsize/arburst   AR request fields, arvalid/arready handshake
//   mem_re/mem_addr/mem_rdata          synchronous memory read port (data 1 cycle after mem_re)
//   rid/rdata/rresp/rlast              R beat fields, rvalid/rready handshake
//   busy                               burst in progress
module axi_rd_burst_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              busy
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  state_t state_q, state_n;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              arready_q;
  logic              resp_first_q;

  logic              capture;
  logic              advance;
  logic              mem_re_c;
  logic              ar_err;
  logic              last_beat;
  logic              wrap_len_ok;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] rdata_live;

  assign last_beat = (cnt_q == len_q);

  // Request legality, evaluated on the incoming AR fields at capture time.
  assign wrap_len_ok = (arlen == LEN_W'(1)) || (arlen == LEN_W'(3)) ||
                       (arlen == LEN_W'(7)) || (arlen == LEN_W'(15));
  assign ar_err = (arburst == 2'b11) ||
                  ((arburst == 2'b10) && !wrap_len_ok) ||
                  (arsize > 3'(MAX_SIZE));

  // Next beat address. The wrap window is (len+1)*step bytes, always a power of two
  // because only legal WRAP lengths reach here, so a shift and a mask suffice.
  always_comb begin
    step      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    incr_addr = addr_q + step;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  // FSM next state and control strobes.
  always_comb begin
    state_n  = state_q;
    capture  = 1'b0;
    advance  = 1'b0;
    mem_re_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready_q) begin
          capture = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_re_c = !err_q;
        state_n  = S_RESP;
      end
      S_RESP: begin
        if (rready) begin
          if (last_beat) begin
            state_n = S_IDLE;
          end else begin
            advance = 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      arready_q    <= 1'b0;
      resp_first_q <= 1'b0;
    end else begin
      // Registered so arready stays low through reset and rises one cycle after release.
      arready_q    <= (state_n == S_IDLE);
      resp_first_q <= (state_q == S_FETCH);
      if (capture) begin
        id_q    <= arid;
        addr_q  <= araddr;
        len_q   <= arlen;
        size_q  <= arsize;
        burst_q <= arburst;
        err_q   <= ar_err;
        cnt_q   <= '0;
      end else if (advance) begin
        cnt_q  <= cnt_q + LEN_W'(1);
        addr_q <= next_addr;
      end
      if (resp_first_q) begin
        rdata_q <= rdata_live;
      end
    end
  end

  // The memory delivers data in the cycle after mem_re, which is the first RESP cycle.
  // That cycle forwards it straight through and latches it, so a stalled beat keeps
  // its data even if the memory output moves on.
  assign rdata_live = err_q ? '0 : mem_rdata;
  assign rdata      = ((state_q == S_RESP) && resp_first_q) ? rdata_live : rdata_q;

  assign arready  = arready_q;
  assign busy     = (state_q != S_IDLE);
  assign rvalid   = (state_q == S_RESP);
  assign rlast    = (state_q == S_RESP) && last_beat;
  assign rresp    = err_q ? 2'b10 : 2'b00;
  assign rid      = id_q;
  assign mem_re   = mem_re_c;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_axi_rd_burst_seq.sv
// Purpose: directed self-checking bench for axi_rd_burst_seq.
// Latency: checks AR->mem_re->rvalid timing and per-beat handshake cycle by cycle.
// Backpressure: exercises rready stalls and reset in the middle of a burst.
module tb_axi_rd_burst_seq;

  logic        clk;
  logic        rst_n;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        busy;

  int n_cmp;
  int n_err;
  int mem_re_cnt;
  logic [31:0] exp_addr [16];

  axi_rd_burst_seq #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .ID_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous memory: data one cycle after mem_re, garbage on cycles without a read.
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata  <= mem_f(mem_addr);
      mem_re_cnt <= mem_re_cnt + 1;
    end else begin
      mem_rdata <= $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input string nm, input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic err, input int stall_beat, input int stall_n);
    int re0;
    logic [31:0] expd;
    logic [37:0] got;
    logic [37:0] want;
    for (int k = 0; k < 20 && arready !== 1'b1; k++) tick();
    re0     = mem_re_cnt;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    n_cmp++;
    if (arready !== 1'b1) begin
      n_err++;
      $display("FAIL %s arready: got %b want 1", nm, arready);
    end
    tick();
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n_cmp++;
      if (mem_re !== !err || rvalid !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s fetch%0d mem_re/rvalid/busy: got %b%b%b want %b01", nm, b, mem_re, rvalid, busy, !err);
      end
      if (!err) begin
        n_cmp++;
        if (mem_addr !== exp_addr[b]) begin
          n_err++;
          $display("FAIL %s mem_addr%0d: got %h want %h", nm, b, mem_addr, exp_addr[b]);
        end
      end
      tick();
      expd = err ? 32'h0 : mem_f(exp_addr[b]);
      got  = {rvalid, rlast, rresp, id == rid ? 2'b00 : 2'b11, rdata};
      want = {1'b1, b == int'(len), err ? 2'b10 : 2'b00, 2'b00, expd};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s beat%0d {rvalid,rlast,rresp,idbad,rdata}: got %h want %h (rid %h)", nm, b, got, want, rid);
      end
      if (b == stall_beat) begin
        rready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          n_cmp++;
          if ({rvalid, rlast, rid, rdata, mem_re} !== {1'b1, b == int'(len), id, expd, 1'b0}) begin
            n_err++;
            $display("FAIL %s stall%0d {rvalid,rlast,rid,rdata,mem_re}: got %b %b %h %h %b want 1 %b %h %h 0",
                     nm, k, rvalid, rlast, rid, rdata, mem_re, b == int'(len), id, expd);
          end
        end
        rready = 1'b1;
      end
      tick();
    end
    n_cmp++;
    if (arready !== 1'b1 || busy !== 1'b0 || rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s end arready/busy/rvalid: got %b%b%b want 100", nm, arready, busy, rvalid);
    end
    n_cmp++;
    if (mem_re_cnt - re0 !== (err ? 0 : int'(len) + 1)) begin
      n_err++;
      $display("FAIL %s mem_re count: got %0d want %0d", nm, mem_re_cnt - re0, err ? 0 : int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({arready, busy, rvalid, rlast, mem_re, rresp, rid, rdata} !== 47'h0) begin
      n_err++;
      $display("FAIL reset outputs: got ar%b bs%b rv%b rl%b re%b rr%b id%h d%h want all 0",
               arready, busy, rvalid, rlast, mem_re, rresp, rid, rdata);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (arready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset release arready/busy: got %b%b want 10", arready, busy);
    end
  endtask

  task automatic test_incr();
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108; exp_addr[3] = 32'h10C;
    run_burst("incr", 8'h11, 32'h100, 4'd3, 3'd2, 2'b01, 1'b0, -1, 0);
  endtask

  task automatic test_wrap();
    exp_addr[0] = 32'h108; exp_addr[1] = 32'h10C; exp_addr[2] = 32'h100; exp_addr[3] = 32'h104;
    run_burst("wrap4", 8'h22, 32'h108, 4'd3, 3'd2, 2'b10, 1'b0, -1, 0);
    exp_addr[0] = 32'h1C; exp_addr[1] = 32'h1E; exp_addr[2] = 32'h10; exp_addr[3] = 32'h12;
    exp_addr[4] = 32'h14; exp_addr[5] = 32'h16; exp_addr[6] = 32'h18; exp_addr[7] = 32'h1A;
    run_burst("wrap8h", 8'h23, 32'h1C, 4'd7, 3'd1, 2'b10, 1'b0, -1, 0);
  endtask

  task automatic test_fixed_single();
    exp_addr[0] = 32'h20; exp_addr[1] = 32'h20;
    run_burst("fixed", 8'h33, 32'h20, 4'd1, 3'd2, 2'b00, 1'b0, -1, 0);
    exp_addr[0] = 32'h40;
    run_burst("single", 8'h34, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, -1, 0);
  endtask

  task automatic test_stall();
    exp_addr[0] = 32'h300; exp_addr[1] = 32'h304; exp_addr[2] = 32'h308; exp_addr[3] = 32'h30C;
    run_burst("stall", 8'h44, 32'h300, 4'd3, 3'd2, 2'b01, 1'b0, 1, 5);
  endtask

  task automatic test_errors();
    run_burst("err_wrap3", 8'h55, 32'h100, 4'd2, 3'd2, 2'b10, 1'b1, -1, 0);
    run_burst("err_rsvd", 8'h56, 32'h100, 4'd2, 3'd2, 2'b11, 1'b1, 0, 2);
    run_burst("err_size", 8'h57, 32'h100, 4'd0, 3'd3, 2'b01, 1'b1, -1, 0);
  endtask

  task automatic test_back_to_back();
    exp_addr[0] = 32'hFFFF_FFFC; exp_addr[1] = 32'h0;
    run_burst("b2b_wrap32", 8'h61, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 1'b0, -1, 0);
    exp_addr[0] = 32'h500; exp_addr[1] = 32'h501;
    run_burst("b2b_byte", 8'h62, 32'h500, 4'd1, 3'd0, 2'b01, 1'b0, -1, 0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 20 && arready !== 1'b1; k++) tick();
    arid = 8'h77; araddr = 32'h200; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || rlast !== 1'b0 || rdata !== mem_f(32'h204)) begin
      n_err++;
      $display("FAIL rstmid beat2: got rv%b rl%b d%h want rv1 rl0 d%h", rvalid, rlast, rdata, mem_f(32'h204));
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid, busy, arready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid in reset rvalid/busy/arready: got %b%b%b want 000", rvalid, busy, arready);
    end
    tick();
    n_cmp++;
    if ({rvalid, busy, arready, mem_re} !== 4'b0000) begin
      n_err++;
      $display("FAIL rstmid held rvalid/busy/arready/mem_re: got %b%b%b%b want 0000", rvalid, busy, arready, mem_re);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid release arready/rvalid: got %b%b want 10", arready, rvalid);
    end
    exp_addr[0] = 32'h400; exp_addr[1] = 32'h404;
    run_burst("post_rst", 8'h78, 32'h400, 4'd1, 3'd2, 2'b01, 1'b0, -1, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem_re_cnt = 0;
    rst_n = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_single();
    test_stall();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
